// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode encodings, instruction field positions
// and the fetch-stage occupancy encoding.
package pipe_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_INC = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_CMP = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 4'b1011;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'b1111;
  localparam logic [OPCODE_W-1:0] OP_LD  = 4'b1101;
  localparam logic [OPCODE_W-1:0] OP_ST  = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_RES = 4'b1100;

  // Bubble word for the default 16-bit instruction width.
  localparam logic [15:0] NOP_INSTR = {12'h000, OP_NOP};

  // Instruction field positions.
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RA_LSB  = 5;
  localparam int unsigned RB_LSB  = 9;
  localparam int unsigned FIELD_W = 4;

  // Fetch occupancy as {skid_valid, inflight_valid}; 2'b11 must never occur.
  typedef enum logic [1:0] {
    FETCH_EMPTY    = 2'b00,
    FETCH_INFLIGHT = 2'b01,
    FETCH_HELD     = 2'b10
  } fetch_cond_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register. Clear has priority over load.
module fetch_skid_buf #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  // Capture a word on load, drop it on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency imem and
// holds the IF/ID register. A stalled-cycle arrival is parked in the skid
// buffer; a redirect flushes everything not yet on if_*.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned    INSTR_W  = 16,
  parameter int unsigned    PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_en,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [PC_W-1:0]     if_pc,
  output logic                if_valid
);

  localparam logic [INSTR_W-1:0] NOP_WORD = {{(INSTR_W - OPCODE_W){1'b0}}, OP_NOP};

  logic               r_fetch_pc_valid_unused;
  logic [PC_W-1:0]    r_fetch_pc;
  logic               r_inflight_valid;
  logic [PC_W-1:0]    r_inflight_pc;
  logic [INSTR_W-1:0] r_if_instr;
  logic [PC_W-1:0]    r_if_pc;
  logic               r_if_valid;

  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc;
  logic               w_skid_load;
  logic               w_skid_clear;
  fetch_cond_e        w_cond;

  assign r_fetch_pc_valid_unused = 1'b0;

  assign imem_en   = !stall && !redirect;
  assign imem_addr = r_fetch_pc;

  // Park the word arriving during a stall; drain it on the first free cycle.
  assign w_skid_load  = !redirect && stall && r_inflight_valid && !w_skid_valid;
  assign w_skid_clear = redirect || (!stall && w_skid_valid);

  fetch_skid_buf #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_inflight_pc),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  // Program counter and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc       <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
    end else if (redirect) begin
      r_fetch_pc       <= redirect_pc;
      r_inflight_valid <= 1'b0;
    end else if (imem_en) begin
      r_fetch_pc       <= r_fetch_pc + PC_W'(1);
      r_inflight_valid <= 1'b1;
      r_inflight_pc    <= r_fetch_pc;
    end else begin
      r_inflight_valid <= 1'b0;
    end
  end

  // IF/ID register: skid first, then the arriving word, else a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_instr <= NOP_WORD;
      r_if_pc    <= '0;
      r_if_valid <= 1'b0;
    end else if (redirect) begin
      r_if_instr <= NOP_WORD;
      r_if_valid <= 1'b0;
    end else if (!stall) begin
      if (w_skid_valid) begin
        r_if_instr <= w_skid_instr;
        r_if_pc    <= w_skid_pc;
        r_if_valid <= 1'b1;
      end else if (r_inflight_valid) begin
        r_if_instr <= imem_rdata;
        r_if_pc    <= r_inflight_pc;
        r_if_valid <= 1'b1;
      end else begin
        r_if_instr <= NOP_WORD;
        r_if_valid <= 1'b0;
      end
    end
  end

  assign if_instr  = r_if_instr;
  assign if_opcode = r_if_instr[OPC_LSB +: OPCODE_W];
  assign if_pc     = r_if_pc;
  assign if_valid  = r_if_valid;

  // Issue stops while stalled, so the skid and an in-flight read never coexist.
  assign w_cond = fetch_cond_e'({w_skid_valid, r_inflight_valid});

  a_no_skid_and_inflight : assert property (
    @(posedge clk) disable iff (rst)
    (w_cond == FETCH_EMPTY) || (w_cond == FETCH_INFLIGHT) || (w_cond == FETCH_HELD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table-driven per-cycle vectors plus a scoreboard of
// expected {pc, instr} pushed when a fetch is issued and popped on output.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [15:0] if_instr;
  logic [3:0]  if_opcode;
  logic [7:0]  if_pc;
  logic        if_valid;

  fetch_stage #(
    .INSTR_W  (16),
    .PC_W     (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_instr    (if_instr),
    .if_opcode   (if_opcode),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [7:0] a);
    return {4'h0, a, 4'h1};
  endfunction

  // Synchronous imem, 1-cycle latency.
  always @(posedge clk) if (imem_en) imem_rdata <= mk(imem_addr);

  typedef struct {
    logic       stall;
    logic       redirect;
    logic [7:0] tgt;
    logic       exp_valid;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0]  model_pc;
  logic [7:0]  last_pc;
  logic [15:0] last_instr;
  logic        last_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic rd, input logic [7:0] tgt,
                     input logic ev, input int n);
    vec_t v;
    v.stall = st; v.redirect = rd; v.tgt = tgt; v.exp_valid = ev;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic model_reset();
    sb.delete();
    model_pc   = 8'h00;
    last_pc    = 8'h00;
    last_instr = 16'h0008;
    last_valid = 1'b0;
  endtask

  // Called at a negedge: drive one cycle of inputs, then check the result.
  task automatic step(input vec_t v);
    exp_t e;
    stall = v.stall; redirect = v.redirect; redirect_pc = v.tgt;
    #1;
    chk("imem_en", {31'b0, imem_en}, {31'b0, !v.stall && !v.redirect});
    if (v.redirect) begin
      sb.delete();
      model_pc = v.tgt;
    end else if (!v.stall) begin
      chk("imem_addr", {24'b0, imem_addr}, {24'b0, model_pc});
      e.pc = model_pc; e.instr = mk(model_pc);
      sb.push_back(e);
      model_pc = model_pc + 8'd1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("if_valid", {31'b0, if_valid}, {31'b0, v.exp_valid});
    if (v.stall && !v.redirect) begin
      chk("hold_instr", {16'b0, if_instr}, {16'b0, last_instr});
      if (last_valid) chk("hold_pc", {24'b0, if_pc}, {24'b0, last_pc});
    end else if (if_valid) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("if_pc", {24'b0, if_pc}, {24'b0, e.pc});
        chk("if_instr", {16'b0, if_instr}, {16'b0, e.instr});
        chk("if_opcode", {28'b0, if_opcode}, {28'b0, e.instr[3:0]});
        last_pc = e.pc; last_instr = e.instr; last_valid = 1'b1;
      end
    end else begin
      chk("bubble_instr", {16'b0, if_instr}, 32'h0008);
      chk("bubble_opcode", {28'b0, if_opcode}, 32'h8);
      last_instr = 16'h0008; last_valid = 1'b0;
    end
  endtask

  task automatic run_vq();
    foreach (vq[i]) step(vq[i]);
    vq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
    chk({tag, "_instr"}, {16'b0, if_instr}, 32'h0008);
    chk({tag, "_pc"}, {24'b0, if_pc}, 32'd0);
    chk({tag, "_addr"}, {24'b0, imem_addr}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    model_reset();
    #1;
    chk("cycle0_valid", {31'b0, if_valid}, 32'd0);
  endtask

  initial begin
    // Reset release, fill to pc 5, stall 3 cycles, release.
    do_reset();
    add(0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 6);
    add(1, 0, 8'h00, 1, 3);
    add(0, 0, 8'h00, 1, 4);
    run_vq();

    // Redirect to 0x40 while pc 3 is on if_*.
    do_reset();
    add(0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 4);
    add(0, 1, 8'h40, 0, 1);
    add(0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 3);
    // Redirect together with stall while the skid holds a stale word.
    add(1, 0, 8'h00, 1, 2);
    add(1, 1, 8'h20, 0, 1);
    add(0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 3);
    // Wrap-around from 0xFF.
    add(0, 1, 8'hFF, 0, 1);
    add(0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 3);
    run_vq();

    // Async reset mid-stall with the skid full.
    do_reset();
    add(0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 3);
    add(1, 0, 8'h00, 1, 2);
    run_vq();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    stall = 1'b0;
    rst = 1'b0;
    model_reset();
    add(0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 3);
    run_vq();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage with IF/ID pipeline register, directly upstream of the control unit.
- Owns the program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Registers the fetched word plus its PC; opcode bits [3:0] feed the control unit.
- Handles pipeline stall with a 1-entry skid buffer and branch/jump redirect with flush-to-NOP.

Parameters:
- INSTR_W, 16: instruction width; opcode = bits [3:0].
- PC_W, 8: program counter / imem address width.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- imem_en  out  1  read strobe; equals !stall && !redirect (combinational from inputs).
- imem_addr  out  PC_W  read address; equals fetch_pc register.
- imem_rdata  in  INSTR_W  read data, valid in the cycle after imem_en was high.
- stall  in  1  hold the IF/ID register and stop issuing fetches.
- redirect  in  1  taken BEQ or JMP; flush and restart at redirect_pc.
- redirect_pc  in  PC_W  restart address.
- if_instr  out  INSTR_W  IF/ID instruction; NOP_INSTR when invalid.
- if_opcode  out  4  if_instr[3:0], to control unit opcode input.
- if_pc  out  PC_W  PC of if_instr.
- if_valid  out  1  if_instr is a real fetched instruction, not a bubble.

Behaviour:
- Reset (async) values:
  - fetch_pc = RESET_PC; inflight_valid = 0; skid_valid = 0.
  - if_instr = NOP_INSTR (opcode 1000); if_pc = 0; if_valid = 0.
  - A reset mid-operation discards any in-flight read and the skid contents.
- Internal state:
  - inflight_valid / inflight_pc: a read was issued last cycle, so imem_rdata is meaningful this cycle.
  - Control condition is implicit in {inflight_valid, skid_valid}: EMPTY, INFLIGHT, HELD. {1,1} is illegal; assert on it.
- Fetch issue:
  - When imem_en = 1: fetch_pc <= fetch_pc + 1, wrapping 2^PC_W-1 -> 0; inflight_valid <= 1; inflight_pc <= fetch_pc.
  - Otherwise inflight_valid <= 0.
- Priority, per cycle: rst > redirect > stall > normal.
- Redirect, regardless of stall:
  - fetch_pc <= redirect_pc; inflight_valid <= 0 (arriving word dropped); skid_valid <= 0.
  - if_instr <= NOP_INSTR; if_valid <= 0.
  - Target issued in cycle t+1, arrives t+2, visible on if_* in t+3.
- Stall (no redirect):
  - if_* hold; no fetch issued.
  - If inflight_valid and !skid_valid: skid <= {imem_rdata, inflight_pc}; skid_valid <= 1.
  - Because issue stops during stall, at most one word arrives, so depth 1 is sufficient.
- Normal (no stall, no redirect), IF/ID loads from the first available source:
  - skid_valid: load from skid, set skid_valid <= 0, if_valid <= 1;
  - else inflight_valid: load {imem_rdata, inflight_pc}, if_valid <= 1;
  - else load NOP_INSTR, if_valid <= 0.
- Throughput and latency:
  - Steady state is 1 instruction/cycle.
  - After reset deassert, the first fetch issues in cycle 0 and RESET_PC's word is visible in cycle 2.
- Stall release: the skid word is output on the first unstalled edge. A fetch of the next PC issues in the same cycle, so no instruction is lost or duplicated.

Decomposition:
- Shared package pipe_pkg:
  - OPCODE_W = 4.
  - Opcode constants: NOP 1000, ADD 0001, MUL 0010, XOR 0100, INC 0011, CMP 0110, BEQ 1011, JMP 1111, LD 1101, ST 1010, RES 1100.
  - NOP_INSTR = zero-extended 4'b1000.
  - Instruction field positions: opcode [3:0], register fields [8:5] and [12:9].
- Sub-module fetch_skid_buf:
  - 1-entry {instr, pc} holding register with load/clear/valid.
  - Reused later by the decode stage.

Test Plan:
- Bench imem: mem[a] = {4'h0, a, 4'h1}. Reset release, no stall -> if_valid = 0 in cycles 0–1; cycle 2: if_pc = 0, if_instr = 16'h0001; cycle 3: if_pc = 1, if_instr = 16'h0011.
- With if_pc = 5, stall for 3 cycles -> if_pc stays 5, imem_en = 0. After release, if_pc = 6, then 7, with no gaps or duplicates.
- redirect = 1 with redirect_pc = 8'h40 while if_pc = 3 -> next edge if_valid = 0 and if_opcode = 1000. Two bubble cycles total, then if_pc = 8'h40, if_instr = 16'h0401.
- redirect and stall asserted together -> redirect wins. The skid is cleared and the stale word is never output.
- Redirect to 8'hFF, run -> if_pc sequence FF, 00, 01 (wrap-around).
- Assert rst asynchronously mid-stall with the skid full -> all outputs reset immediately. After release, the fetch restarts at RESET_PC and the first valid word appears 2 cycles later.
